// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM encoding and default timing for the button debouncer
//
// Purpose:
//   Holds the debouncer FSM state encoding (2-bit) and the default cycle
//   constants for a 50 MHz system clock. Imported by button_debouncer.
//
// Contents:
//   state_t            IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT
//   DEF_STABLE_CYCLES  20 ms at 50 MHz
//   DEF_REPEAT_CYCLES  500 ms at 50 MHz
//   DEF_CNT_WIDTH      wide enough for both defaults

package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_REPEAT_CYCLES = 25000000;
  localparam int DEF_CNT_WIDTH     = 25;

endpackage

// File: rtl/input_sync2.sv
// rtl/input_sync2.sv - generic two-flop level synchronizer
//
// Purpose:
//   Brings one asynchronous level signal into the clk domain through two
//   flops. Both flops clear to 0 on reset. Reusable for any switch input.
//
// Ports:
//   clk     in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   d       in   asynchronous level
//   q       out  synchronized level (two clk edges of latency)

module input_sync2 (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounced level and press/release pulses for one push-button
//
// Purpose:
//   Synchronizes a raw mechanical button, then accepts a level change only
//   after the synchronized value has held for STABLE_CYCLES consecutive
//   edges. Emits a registered level plus one-cycle press/release pulses.
//
// Configuration:
//   BUTTON_DEBOUNCER_AUTOREPEAT_EN  when defined, a held button re-issues
//                                   press_pulse every REPEAT_CYCLES cycles.
//
// Parameters:
//   STABLE_CYCLES  qualification length in cycles (>= 2)
//   REPEAT_CYCLES  auto-repeat period (only with the autorepeat macro)
//   CNT_WIDTH      counter width, must hold max(STABLE_CYCLES, REPEAT_CYCLES)
//
// Ports:
//   clk            in   system clock, rising edge
//   resetn         in   asynchronous active-low reset (from reset synchronizer)
//   btn_in         in   raw button, active-high, asynchronous
//   btn_level      out  debounced level, registered
//   press_pulse    out  one-cycle pulse on accepted press (and each repeat)
//   release_pulse  out  one-cycle pulse on accepted release

module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam longint CNT_CAP  = longint'(1) << CNT_WIDTH;
  localparam longint CNT_NEED = (STABLE_CYCLES > REPEAT_CYCLES) ?
                                longint'(STABLE_CYCLES) : longint'(REPEAT_CYCLES);

  // Elaboration-time guards on the parameter set.
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("button_debouncer: STABLE_CYCLES must be at least 2");
  end
  if (CNT_CAP <= CNT_NEED) begin : g_bad_width
    $error("button_debouncer: CNT_WIDTH too small for the cycle counts");
  end

  // The edge that moves IDLE->PRESS_WAIT (or PRESSED->RELEASE_WAIT) already
  // counts as the first stable observation, so the wait state accepts when
  // the counter reaches STABLE_CYCLES-2.
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  // Counter is cleared on entry to PRESSED; REPEAT_CYCLES edges later it is
  // at REPEAT_CYCLES-1 and the repeat fires.
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
`endif

  logic                 s;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;

  input_sync2 u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (btn_in),
    .q      (s)
  );

  // Saturating increment: the counter can never wrap back into the
  // acceptance window and fire a spurious pulse.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != CNT_MAX) begin
      cnt_inc = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (s) begin
            state <= ST_PRESS_WAIT;
          end
        end

        ST_PRESS_WAIT: begin
          if (!s) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt >= STABLE_LAST) begin
            state       <= ST_PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_PRESSED: begin
          if (!s) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= '0;
          end else begin
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
            if (cnt >= REPEAT_LAST) begin
              press_pulse <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt_inc;
            end
`else
            cnt <= '0;
`endif
          end
        end

        ST_RELEASE_WAIT: begin
          if (s) begin
            state <= ST_PRESSED;
            cnt   <= '0;
          end else if (cnt >= STABLE_LAST) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer

module tb_button_debouncer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  button_debouncer #(
    .STABLE_CYCLES (4),
    .REPEAT_CYCLES (10),
    .CNT_WIDTH     (25)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Edge k is the k-th rising edge after the call; outputs sampled 1 after it.
  // pe/re: edge at which press/release pulse is expected (-1 = none).
  task automatic watch(input string tag, input int n, input int pe, input int re,
                       input logic l0);
    logic lvl;
    lvl = l0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == pe) lvl = 1'b1;
      if (k == re) lvl = 1'b0;
      check($sformatf("%s_press_e%0d", tag, k), press_pulse, k == pe);
      check($sformatf("%s_release_e%0d", tag, k), release_pulse, k == re);
      check($sformatf("%s_level_e%0d", tag, k), btn_level, lvl);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_p;
    logic prev_r;
    logic exp_p;
    logic lvl;

    // Reset state
    #1;
    check("rst_level", btn_level, 1'b0);
    check("rst_press", press_pulse, 1'b0);
    check("rst_release", release_pulse, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    watch("idle", 3, -1, -1, 1'b0);

    // Clean press
    @(negedge clk);
    btn_in = 1'b1;
    watch("press", 8, 5, -1, 1'b0);

    // Clean release
    @(negedge clk);
    btn_in = 1'b0;
    watch("release", 8, -1, 5, 1'b1);

    // Bounce 1,0,1,0 every 2 cycles, then hold 1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_in = (i % 2 == 0);
      watch($sformatf("bounce%0d", i), 2, -1, -1, 1'b0);
    end
    @(negedge clk);
    btn_in = 1'b1;
    watch("bounce_final", 8, 5, -1, 1'b0);

    // Release with a 3-cycle high glitch in RELEASE_WAIT
    @(negedge clk);
    btn_in = 1'b0;
    watch("rel_pre", 3, -1, -1, 1'b1);
    @(negedge clk);
    btn_in = 1'b1;
    watch("rel_glitch", 3, -1, -1, 1'b1);
    @(negedge clk);
    btn_in = 1'b0;
    watch("rel_after", 8, -1, 5, 1'b1);

    // Reset mid-press: asynchronous clear, fresh qualification after release
    @(negedge clk);
    btn_in = 1'b1;
    watch("pre_reset", 8, 5, -1, 1'b0);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("async_rst_level", btn_level, 1'b0);
    check("async_rst_press", press_pulse, 1'b0);
    check("async_rst_release", release_pulse, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    watch("post_reset", 8, 5, -1, 1'b0);

    // Release, then hold 40 cycles for auto-repeat behaviour
    @(negedge clk);
    btn_in = 1'b0;
    watch("rep_pre", 8, -1, 5, 1'b1);
    @(negedge clk);
    btn_in = 1'b1;
    lvl = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      exp_p = (k == 5) || (AUTOREP && (k == 15 || k == 25 || k == 35));
      if (k == 5) lvl = 1'b1;
      check($sformatf("hold_press_e%0d", k), press_pulse, exp_p);
      check($sformatf("hold_release_e%0d", k), release_pulse, 1'b0);
      check($sformatf("hold_level_e%0d", k), btn_level, lvl);
    end
    @(negedge clk);
    btn_in = 1'b0;
    watch("rep_release", 8, -1, 5, 1'b1);

    // Random bounce: pulses exclusive and one cycle wide
    prev_p = 1'b0;
    prev_r = 1'b0;
    for (int c = 0; c < 10000; ) begin
      int run;
      run = $urandom_range(1, 8);
      @(negedge clk);
      btn_in = $urandom_range(0, 1) == 1;
      for (int j = 0; j < run; j++) begin
        @(posedge clk);
        #1;
        check("excl", press_pulse & release_pulse, 1'b0);
        check("press_width", press_pulse & prev_p, 1'b0);
        check("release_width", release_pulse & prev_r, 1'b0);
        prev_p = press_pulse;
        prev_r = release_pulse;
        c++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
